// File: rtl/ps_regfile_pkg.sv
// ps_regfile_pkg: shared write-FSM state enum, out-of-range read value and index range helper
package ps_regfile_pkg;
  typedef enum logic {W_IDLE, W_WAIT} wstate_e;
  localparam logic [63:0] RD_OOR_VAL = '1;
  function automatic logic reg_idx_valid(input logic [31:0] idx, input int unsigned mem_size);
    return idx < mem_size;
  endfunction
endpackage

// File: rtl/ps_regfile_wr_arb.sv
// ps_regfile_wr_arb: PS write FSM with fixed-priority PS/PL arbitration; in: clk rst ps_write_req windex wdata pl_wr_*; out: wcomplete pl_wr_ready we wr_index wr_data
module ps_regfile_wr_arb
  import ps_regfile_pkg::*;
#(
  parameter int MEM_SIZE = 16,
  parameter int DATA_W = 32,
  parameter int IDX_W = 32,
  parameter logic [MEM_SIZE-1:0] RO_MASK = '0,
  localparam int AW = $clog2(MEM_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps_write_req,
  input  logic [IDX_W-1:0]  windex,
  input  logic [DATA_W-1:0] wdata,
  output logic              wcomplete,
  input  logic              pl_wr_valid,
  input  logic [IDX_W-1:0]  pl_wr_index,
  input  logic [DATA_W-1:0] pl_wr_data,
  output logic              pl_wr_ready,
  output logic              we,
  output logic [AW-1:0]     wr_index,
  output logic [DATA_W-1:0] wr_data
);
  wstate_e state_q, state_d;
  logic wcomplete_q, wcomplete_d;
  logic ps_go, ps_legal, pl_legal;
  always_comb begin
    ps_go = state_q == W_IDLE && ps_write_req;
    ps_legal = reg_idx_valid(32'(windex), MEM_SIZE) && !RO_MASK[windex[AW-1:0]];
    pl_legal = pl_wr_valid && reg_idx_valid(32'(pl_wr_index), MEM_SIZE);
    state_d = ps_go ? W_WAIT : ps_write_req ? state_q : W_IDLE;
    wcomplete_d = ps_go;
  end
  assign pl_wr_ready = !ps_go;
  assign we = !rst && (ps_go ? ps_legal : pl_legal);
  assign wr_index = ps_go ? windex[AW-1:0] : pl_wr_index[AW-1:0];
  assign wr_data = ps_go ? wdata : pl_wr_data;
  assign wcomplete = wcomplete_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= W_IDLE;
      wcomplete_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcomplete_q <= wcomplete_d;
    end
  end
endmodule

// File: rtl/ps_regfile.sv
// ps_regfile: PS/PL-writable register bank with tagged PS reads; in: clk rst ps write, rd_req/rd_index, pl_wr_*; out: wcomplete have_rdata rdata_out rindex_out pl_wr_ready reg_q reg_wr_pulse
module ps_regfile
  import ps_regfile_pkg::*;
#(
  parameter int MEM_SIZE = 16,
  parameter int DATA_W = 32,
  parameter int IDX_W = 32,
  parameter logic [MEM_SIZE-1:0] RO_MASK = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ps_write_req,
  input  logic [IDX_W-1:0]           windex,
  input  logic [DATA_W-1:0]          wdata,
  output logic                       wcomplete,
  input  logic                       rd_req,
  input  logic [IDX_W-1:0]           rd_index,
  output logic                       have_rdata,
  output logic [DATA_W-1:0]          rdata_out,
  output logic [IDX_W-1:0]           rindex_out,
  input  logic                       pl_wr_valid,
  input  logic [IDX_W-1:0]           pl_wr_index,
  input  logic [DATA_W-1:0]          pl_wr_data,
  output logic                       pl_wr_ready,
  output logic [MEM_SIZE*DATA_W-1:0] reg_q,
  output logic [MEM_SIZE-1:0]        reg_wr_pulse
);
  localparam int AW = $clog2(MEM_SIZE);
  logic [DATA_W-1:0] mem_q [MEM_SIZE];
  logic [DATA_W-1:0] mem_d [MEM_SIZE];
  logic [MEM_SIZE-1:0] pulse_q, pulse_d;
  logic have_rdata_q, have_rdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [IDX_W-1:0] rindex_q, rindex_d;
  logic we;
  logic [AW-1:0] wr_index;
  logic [DATA_W-1:0] wr_data;
  ps_regfile_wr_arb #(
    .MEM_SIZE(MEM_SIZE),
    .DATA_W(DATA_W),
    .IDX_W(IDX_W),
    .RO_MASK(RO_MASK)
  ) u_wr_arb (
    .clk(clk),
    .rst(rst),
    .ps_write_req(ps_write_req),
    .windex(windex),
    .wdata(wdata),
    .wcomplete(wcomplete),
    .pl_wr_valid(pl_wr_valid),
    .pl_wr_index(pl_wr_index),
    .pl_wr_data(pl_wr_data),
    .pl_wr_ready(pl_wr_ready),
    .we(we),
    .wr_index(wr_index),
    .wr_data(wr_data)
  );
  always_comb begin
    mem_d = mem_q;
    pulse_d = '0;
    if (we) begin
      mem_d[wr_index] = wr_data;
      pulse_d[wr_index] = 1'b1;
    end
    have_rdata_d = rd_req;
    // reads see mem_q, so a same-cycle write to the same index returns the old value
    rdata_d = !rd_req ? rdata_q :
              reg_idx_valid(32'(rd_index), MEM_SIZE) ? mem_q[rd_index[AW-1:0]] : RD_OOR_VAL[DATA_W-1:0];
    rindex_d = rd_req ? rd_index : rindex_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      pulse_q <= '0;
      have_rdata_q <= 1'b0;
      rdata_q <= '0;
      rindex_q <= '0;
    end else begin
      mem_q <= mem_d;
      pulse_q <= pulse_d;
      have_rdata_q <= have_rdata_d;
      rdata_q <= rdata_d;
      rindex_q <= rindex_d;
    end
  end
  for (genvar i = 0; i < MEM_SIZE; i++) begin : g_flat
    assign reg_q[i*DATA_W +: DATA_W] = mem_q[i];
  end
  assign reg_wr_pulse = pulse_q;
  assign have_rdata = have_rdata_q;
  assign rdata_out = rdata_q;
  assign rindex_out = rindex_q;
endmodule

// File: tb/tb_ps_regfile.sv
// tb_ps_regfile: directed test of ps_regfile against a behavioural register-bank model
module tb_ps_regfile;
  localparam int MS = 16, DW = 32, IW = 32;
  localparam logic [MS-1:0] RO = 16'h0004;
  localparam int FW = MS * DW;
  logic clk = 0, rst = 1;
  logic ps_write_req = 0, rd_req = 0, pl_wr_valid = 0;
  logic [IW-1:0] windex = '0, rd_index = '0, pl_wr_index = '0;
  logic [DW-1:0] wdata = '0, pl_wr_data = '0;
  logic wcomplete, have_rdata, pl_wr_ready;
  logic [DW-1:0] rdata_out;
  logic [IW-1:0] rindex_out;
  logic [FW-1:0] reg_q;
  logic [MS-1:0] reg_wr_pulse;
  ps_regfile #(.MEM_SIZE(MS), .DATA_W(DW), .IDX_W(IW), .RO_MASK(RO)) dut (
    .clk(clk), .rst(rst),
    .ps_write_req(ps_write_req), .windex(windex), .wdata(wdata), .wcomplete(wcomplete),
    .rd_req(rd_req), .rd_index(rd_index), .have_rdata(have_rdata),
    .rdata_out(rdata_out), .rindex_out(rindex_out),
    .pl_wr_valid(pl_wr_valid), .pl_wr_index(pl_wr_index), .pl_wr_data(pl_wr_data),
    .pl_wr_ready(pl_wr_ready), .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
  );
  always #5 clk = ~clk;
  int errs = 0, checks = 0;
  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // model: storage array, a flag for "PS request already served, waiting for it to drop", and expected outputs
  logic [DW-1:0] m [MS];
  bit busy;
  logic e_wc, e_hr;
  logic [DW-1:0] e_rd;
  logic [IW-1:0] e_ri;
  logic [MS-1:0] e_pulse;
  always @(posedge clk) begin
    e_wc = 0;
    e_hr = 0;
    e_pulse = '0;
    if (rst) begin
      foreach (m[i]) m[i] = '0;
      busy = 0;
      e_rd = '0;
      e_ri = '0;
    end else begin
      if (rd_req) begin
        e_hr = 1;
        e_ri = rd_index;
        e_rd = (rd_index < MS) ? m[rd_index[3:0]] : 32'hFFFF_FFFF;
      end
      if (!busy && ps_write_req) begin
        busy = 1;
        e_wc = 1;
        if (windex < MS && !RO[windex[3:0]]) begin
          m[windex[3:0]] = wdata;
          e_pulse[windex[3:0]] = 1;
        end
      end else begin
        if (!ps_write_req) busy = 0;
        if (pl_wr_valid && pl_wr_index < MS) begin
          m[pl_wr_index[3:0]] = pl_wr_data;
          e_pulse[pl_wr_index[3:0]] = 1;
        end
      end
    end
  end
  bit chk_en = 0;
  int wc_cnt = 0;
  int pulse_cnt [MS] = '{default: 0};
  always @(negedge clk) if (chk_en) begin
    logic [FW-1:0] e_flat;
    for (int i = 0; i < MS; i++) e_flat[i*DW +: DW] = m[i];
    chk("wcomplete", wcomplete, e_wc);
    chk("have_rdata", have_rdata, e_hr);
    chk("rdata_out", rdata_out, e_rd);
    chk("rindex_out", rindex_out, e_ri);
    chk("reg_wr_pulse", reg_wr_pulse, e_pulse);
    chk("reg_q", reg_q, e_flat);
    chk("pl_wr_ready", pl_wr_ready, !(!busy && ps_write_req));
    if (wcomplete) wc_cnt++;
    for (int i = 0; i < MS; i++) if (reg_wr_pulse[i]) pulse_cnt[i]++;
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  initial begin
    logic [FW-1:0] snap, lit;
    int wc0;
    @(posedge clk);
    #2 chk_en = 1;
    cyc(1);
    rst = 0;
    chk("reset reg_q", reg_q, '0);
    chk("reset ready", pl_wr_ready, 1'b1);
    chk("reset rdata", rdata_out, '0);
    ps_write_req = 1; windex = 3; wdata = 32'hA5A5_0001;
    cyc(5);
    ps_write_req = 0;
    cyc(2);
    chk("t1 wc count", wc_cnt, 1);
    chk("t1 reg3", reg_q[3*DW +: DW], 32'hA5A5_0001);
    chk("t1 pulse3", pulse_cnt[3], 1);
    ps_write_req = 1; windex = 2; wdata = 32'h1234;
    cyc(2);
    ps_write_req = 0;
    cyc(2);
    chk("t2 wc count", wc_cnt, 2);
    chk("t2 ro reg2", reg_q[2*DW +: DW], 0);
    chk("t2 ro pulse2", pulse_cnt[2], 0);
    pl_wr_valid = 1; pl_wr_index = 2; pl_wr_data = 32'h55;
    cyc(1);
    pl_wr_valid = 0;
    cyc(1);
    chk("t2 pl reg2", reg_q[2*DW +: DW], 32'h55);
    chk("t2 pl pulse2", pulse_cnt[2], 1);
    ps_write_req = 1; windex = 1; wdata = 32'h111;
    pl_wr_valid = 1; pl_wr_index = 1; pl_wr_data = 32'h222;
    #1 chk("t3 ready low", pl_wr_ready, 1'b0);
    cyc(1);
    chk("t3 ps first", reg_q[1*DW +: DW], 32'h111);
    chk("t3 ready high", pl_wr_ready, 1'b1);
    cyc(1);
    pl_wr_valid = 0; ps_write_req = 0;
    chk("t3 pl last", reg_q[1*DW +: DW], 32'h222);
    cyc(2);
    chk("t3 pulse1", pulse_cnt[1], 2);
    ps_write_req = 1; windex = 4; wdata = 32'hDEAD_0004;
    cyc(1);
    ps_write_req = 0;
    cyc(1);
    rd_req = 1; rd_index = 4;
    cyc(1);
    rd_index = MS;
    chk("t4 have1", have_rdata, 1'b1);
    chk("t4 rdata1", rdata_out, 32'hDEAD_0004);
    chk("t4 rindex1", rindex_out, 4);
    cyc(1);
    rd_req = 0;
    chk("t4 have2", have_rdata, 1'b1);
    chk("t4 rdata2", rdata_out, 32'hFFFF_FFFF);
    chk("t4 rindex2", rindex_out, MS);
    cyc(1);
    chk("t4 have idle", have_rdata, 1'b0);
    chk("t4 rdata held", rdata_out, 32'hFFFF_FFFF);
    snap = reg_q; wc0 = wc_cnt;
    ps_write_req = 1; windex = MS; wdata = 32'h9999;
    cyc(2);
    ps_write_req = 0;
    cyc(2);
    chk("t5 oor unchanged", reg_q, snap);
    chk("t5 oor wc", wc_cnt - wc0, 1);
    ps_write_req = 1; windex = 5; wdata = 32'h5555;
    cyc(2);
    rst = 1;
    cyc(2);
    rst = 0; wc0 = wc_cnt;
    cyc(2);
    chk("t6 recommit wc", wc_cnt - wc0, 1);
    lit = '0;
    lit[5*DW +: DW] = 32'h5555;
    chk("t6 reg_q", reg_q, lit);
    ps_write_req = 0;
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
